reg_bank8x16: RTL and testbench



---
 rtl/reg_bank8x16.sv | 161 ++++++++++++++++
 tb/tb_reg_bank8x16.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank8x16.sv
// reg_bank8x16: eight WIDTH-bit registers with one synchronous write port
// and an 8-cycle sequenced bulk clear. Register contents drive Q0..Q7
// continuously; per-register VALID bits track which entries hold data.

// One register slot: clear beats write, otherwise hold.
module reg_bank8x16_cell #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             vld_q, vld_d;

  // Next-state select for this slot.
  always_comb begin
    q_d   = q_q;
    vld_d = vld_q;
    if (clr_i) begin
      q_d   = '0;
      vld_d = 1'b0;
    end else if (wr_i) begin
      q_d   = wd_i;
      vld_d = 1'b1;
    end
  end

  // Slot storage, cleared immediately on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;
endmodule

module reg_bank8x16 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic             CLR,
  output logic             BUSY,
  output logic             WACK,
  output logic [7:0]       VALID,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7
);
  localparam int NUM_REGS = 8;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  typedef struct packed {
    logic             en;
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wack_q, wack_d;
  wr_req_t    wr_req;

  logic [NUM_REGS-1:0]            wr_sel;
  logic [NUM_REGS-1:0]            clr_sel;
  logic [NUM_REGS-1:0][WIDTH-1:0] q_arr;

  // A write only lands in IDLE and loses to a same-edge CLR.
  always_comb begin
    wr_req.en   = (state_q == IDLE) && !CLR && WE;
    wr_req.addr = WA;
    wr_req.data = WD;
  end

  // Sweep FSM: next state, counter and write-ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wack_d  = wr_req.en;
    unique case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          cnt_d   = 3'd0;
        end
      end
      SWEEP: begin
        cnt_d = 3'(cnt_q + 3'd1);
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wack_q  <= wack_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_sel[i]  = wr_req.en && (wr_req.addr == 3'(i));
    assign clr_sel[i] = (state_q == SWEEP) && (cnt_q == 3'(i));

    reg_bank8x16_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr_i (clr_sel[i]),
      .wr_i  (wr_sel[i]),
      .wd_i  (wr_req.data),
      .q_o   (q_arr[i]),
      .vld_o (VALID[i])
    );
  end

  assign BUSY = (state_q == SWEEP);
  assign WACK = wack_q;

  // Q outputs are never gated; partially cleared contents are visible.
  assign Q0 = q_arr[0];
  assign Q1 = q_arr[1];
  assign Q2 = q_arr[2];
  assign Q3 = q_arr[3];
  assign Q4 = q_arr[4];
  assign Q5 = q_arr[5];
  assign Q6 = q_arr[6];
  assign Q7 = q_arr[7];
endmodule

// File: tb/tb_reg_bank8x16.sv
// Directed bench for reg_bank8x16: writes, sweep timing, priority,
// dropped writes during the sweep and asynchronous reset mid-sweep.
module tb_reg_bank8x16;
  logic        CLK;
  logic        RST_N;
  logic        WE;
  logic [2:0]  WA;
  logic [15:0] WD;
  logic        CLR;
  logic        BUSY;
  logic        WACK;
  logic [7:0]  VALID;
  logic [15:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [15:0] q [8];

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank8x16 #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .WD(WD), .CLR(CLR),
    .BUSY(BUSY), .WACK(WACK), .VALID(VALID),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7)
  );

  assign q[0] = Q0;
  assign q[1] = Q1;
  assign q[2] = Q2;
  assign q[3] = Q3;
  assign q[4] = Q4;
  assign q[5] = Q5;
  assign q[6] = Q6;
  assign q[7] = Q7;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [15:0] base, input logic inc);
    for (int n = 0; n < 8; n++) begin
      WE = 1'b1; WA = 3'(n); WD = inc ? 16'(base + 16'(n)) : base;
      tick();
    end
    WE = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; WE = 1'b0; WA = 3'd0; WD = 16'h0; CLR = 1'b0;
    #12;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (q[n] !== 16'h0) begin
        n_fail++; $display("FAIL reset_q%0d got %h exp 0000", n, q[n]);
      end
    end
    n_checks++;
    if (VALID !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h exp 00", VALID); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL reset_wack got %b exp 0", WACK); end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  // Back-to-back writes to every register; WACK stays high throughout.
  task automatic test_write_all();
    logic [7:0] exp_v;
    exp_v = 8'h00;
    for (int n = 0; n < 8; n++) begin
      WE = 1'b1; WA = 3'(n); WD = 16'(16'h1000 + n);
      tick();
      exp_v[n] = 1'b1;
      n_checks++;
      if (q[n] !== 16'(16'h1000 + n)) begin
        n_fail++; $display("FAIL write_q%0d got %h exp %h", n, q[n], 16'(16'h1000 + n));
      end
      n_checks++;
      if (WACK !== 1'b1) begin n_fail++; $display("FAIL write_wack%0d got %b exp 1", n, WACK); end
      n_checks++;
      if (VALID !== exp_v) begin
        n_fail++; $display("FAIL write_valid%0d got %h exp %h", n, VALID, exp_v);
      end
    end
    WE = 1'b0;
    tick();
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL write_wack_idle got %b exp 0", WACK); end
    n_checks++;
    if (q[4] !== 16'h1004) begin n_fail++; $display("FAIL write_hold_q4 got %h exp 1004", q[4]); end
  endtask

  // CLR pulse: BUSY for 8 cycles, registers clear in order 0..7.
  task automatic test_clear();
    logic [7:0] exp_v;
    CLR = 1'b1;
    tick();                         // E0
    CLR = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL clr_busy_e0 got %b exp 1", BUSY); end
    exp_v = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      tick();                       // Ek clears register k-1
      exp_v[k-1] = 1'b0;
      n_checks++;
      if (q[k-1] !== 16'h0) begin
        n_fail++; $display("FAIL clr_q%0d_e%0d got %h exp 0000", k-1, k, q[k-1]);
      end
      if (k < 8) begin
        n_checks++;
        if (q[k] !== 16'(16'h1000 + k)) begin
          n_fail++; $display("FAIL clr_keep_q%0d_e%0d got %h exp %h", k, k, q[k], 16'(16'h1000 + k));
        end
      end
      n_checks++;
      if (BUSY !== (k < 8)) begin
        n_fail++; $display("FAIL clr_busy_e%0d got %b exp %b", k, BUSY, (k < 8));
      end
      n_checks++;
      if (VALID !== exp_v) begin
        n_fail++; $display("FAIL clr_valid_e%0d got %h exp %h", k, VALID, exp_v);
      end
    end
  endtask

  // CLR beats a same-edge write; writes at E4 and E8 are dropped, E9 lands.
  task automatic test_clr_priority_and_drop();
    WE = 1'b1; WA = 3'd3; WD = 16'h3333;
    tick();
    WE = 1'b1; WA = 3'd3; WD = 16'hBEEF; CLR = 1'b1;
    tick();                         // E0
    WE = 1'b0; CLR = 1'b0;
    n_checks++;
    if (q[3] !== 16'h3333) begin n_fail++; $display("FAIL prio_q3 got %h exp 3333", q[3]); end
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL prio_wack got %b exp 0", WACK); end
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL prio_busy got %b exp 1", BUSY); end
    tick(); tick(); tick();         // E1..E3
    WE = 1'b1; WA = 3'd5; WD = 16'hAAAA;
    tick();                         // E4
    WE = 1'b0;
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL drop_e4_wack got %b exp 0", WACK); end
    n_checks++;
    if (q[5] !== 16'h0) begin n_fail++; $display("FAIL drop_e4_q5 got %h exp 0000", q[5]); end
    tick(); tick(); tick();         // E5..E7
    WE = 1'b1; WA = 3'd5; WD = 16'hAAAA;
    tick();                         // E8
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL drop_e8_busy got %b exp 0", BUSY); end
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL drop_e8_wack got %b exp 0", WACK); end
    n_checks++;
    if (q[5] !== 16'h0) begin n_fail++; $display("FAIL drop_e8_q5 got %h exp 0000", q[5]); end
    n_checks++;
    if (q[3] !== 16'h0) begin n_fail++; $display("FAIL drop_e8_q3 got %h exp 0000", q[3]); end
    tick();                         // E9
    WE = 1'b0;
    n_checks++;
    if (q[5] !== 16'hAAAA) begin n_fail++; $display("FAIL e9_q5 got %h exp AAAA", q[5]); end
    n_checks++;
    if (WACK !== 1'b1) begin n_fail++; $display("FAIL e9_wack got %b exp 1", WACK); end
    n_checks++;
    if (VALID !== 8'h20) begin n_fail++; $display("FAIL e9_valid got %h exp 20", VALID); end
    tick();
    n_checks++;
    if (WACK !== 1'b0) begin n_fail++; $display("FAIL e10_wack got %b exp 0", WACK); end
  endtask

  // CLR held through a sweep restarts a fresh sweep at E9.
  task automatic test_clr_held();
    fill(16'h5A5A, 1'b0);
    CLR = 1'b1;
    for (int k = 0; k <= 8; k++) tick();   // E0..E8
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL held_e8_busy got %b exp 0", BUSY); end
    tick();                         // E9
    CLR = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL held_e9_busy got %b exp 1", BUSY); end
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL held_end_busy got %b exp 0", BUSY); end
  endtask

  // Reset asserted after E3 aborts the sweep without a clock.
  task automatic test_reset_mid_sweep();
    fill(16'hFFFF, 1'b0);
    n_checks++;
    if (VALID !== 8'hFF) begin n_fail++; $display("FAIL rst_fill_valid got %h exp FF", VALID); end
    CLR = 1'b1;
    tick();                         // E0
    CLR = 1'b0;
    tick(); tick(); tick();         // E1..E3
    n_checks++;
    if (q[3] !== 16'hFFFF) begin n_fail++; $display("FAIL rst_pre_q3 got %h exp FFFF", q[3]); end
    RST_N = 1'b0;
    #1;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (q[n] !== 16'h0) begin
        n_fail++; $display("FAIL rst_async_q%0d got %h exp 0000", n, q[n]);
      end
    end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b exp 0", BUSY); end
    n_checks++;
    if (VALID !== 8'h00) begin n_fail++; $display("FAIL rst_async_valid got %h exp 00", VALID); end
    #9;
    RST_N = 1'b1;
    WE = 1'b1; WA = 3'd2; WD = 16'h1357;
    tick();
    WE = 1'b0;
    n_checks++;
    if (q[2] !== 16'h1357) begin n_fail++; $display("FAIL rst_after_q2 got %h exp 1357", q[2]); end
    n_checks++;
    if (WACK !== 1'b1) begin n_fail++; $display("FAIL rst_after_wack got %b exp 1", WACK); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy got %b exp 0", BUSY); end
    n_checks++;
    if (VALID !== 8'h04) begin n_fail++; $display("FAIL rst_after_valid got %h exp 04", VALID); end
  endtask

  // Repeated writes to one address: last write wins.
  task automatic test_back_to_back();
    WE = 1'b1; WA = 3'd6; WD = 16'h1111;
    tick();
    WD = 16'h2222;
    tick();
    WE = 1'b0;
    n_checks++;
    if (q[6] !== 16'h2222) begin n_fail++; $display("FAIL b2b_q6 got %h exp 2222", q[6]); end
    n_checks++;
    if (VALID !== 8'h44) begin n_fail++; $display("FAIL b2b_valid got %h exp 44", VALID); end
    n_checks++;
    if (WACK !== 1'b1) begin n_fail++; $display("FAIL b2b_wack got %b exp 1", WACK); end
  endtask

  initial begin
    test_reset();
    test_write_all();
    test_clear();
    test_clr_priority_and_drop();
    test_clr_held();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
